// File: rtl/backup_memory_pkg.sv
// Shared types and derived widths for the backing-store memory model.
package backup_memory_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int BEAT_BITS  = 2;   // log2(DATA_BEATS) for the default 4-beat line
  localparam int INDEX_BITS = 16;  // log2(DEPTH_WORDS) for the default 64K-word array

endpackage

// File: rtl/backup_memory.sv
// Line-granular backing store: reads stream DATA_BEATS registered beats starting 1 cycle after the command, responses never stall;
// writes stall on data_valid. Optional sticky out-of-range flag mem_err under BACKUP_MEM_BOUNDS_CHECK_EN.
module backup_memory
  import backup_memory_pkg::*;
#(
  parameter int ADDR_BITS   = 26,
  parameter int TAG_BITS    = 5,
  parameter int DATA_BITS   = 128,
  parameter int DATA_BEATS  = 1 << BEAT_BITS,
  parameter int DEPTH_WORDS = 1 << INDEX_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  output logic                 mem_req_ready,
  input  logic                 mem_req_rw,
  input  logic [ADDR_BITS-1:0] mem_req_addr,
  input  logic [TAG_BITS-1:0]  mem_req_tag,
  input  logic                 mem_req_data_valid,
  output logic                 mem_req_data_ready,
  input  logic [DATA_BITS-1:0] mem_req_data_bits,
  output logic                 mem_resp_valid,
  output logic [DATA_BITS-1:0] mem_resp_data,
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
  output logic                 mem_err,
`endif
  output logic [TAG_BITS-1:0]  mem_resp_tag
);

  localparam int CNT_W     = $clog2(DATA_BEATS);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int LINE_BITS = IDX_W - CNT_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_BEATS - 1);

  logic [DATA_BITS-1:0] ram [DEPTH_WORDS];

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_resp_valid;
  logic [DATA_BITS-1:0] r_resp_data;
  logic [TAG_BITS-1:0]  r_resp_tag;

  logic             w_cmd_fire;
  logic             w_dat_fire;
  logic [IDX_W-1:0] w_cmd_idx;
  logic [IDX_W-1:0] w_cur_idx;

  assign mem_req_ready      = (r_state == IDLE) && !reset;
  assign mem_req_data_ready = (r_state == WRITE) && !reset;
  assign w_cmd_fire         = mem_req_valid && mem_req_ready;
  assign w_dat_fire         = mem_req_data_valid && mem_req_data_ready;
  // Upper line-address bits fall off here, which is what makes addresses wrap.
  assign w_cmd_idx          = IDX_W'({mem_req_addr, {CNT_W{1'b0}}});
  assign w_cur_idx          = IDX_W'({r_addr, r_cnt});

  assign mem_resp_valid = r_resp_valid;
  assign mem_resp_data  = r_resp_data;
  assign mem_resp_tag   = r_resp_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_addr <= mem_req_addr;
            if (mem_req_rw) begin
              r_state <= WRITE;
              r_cnt   <= '0;
            end else begin
              // Beat 0 leaves with the handshake, so the counter points at the next beat.
              r_state      <= READ;
              r_cnt        <= CNT_W'(1);
              r_resp_valid <= 1'b1;
              r_resp_data  <= ram[w_cmd_idx];
              r_resp_tag   <= mem_req_tag;
            end
          end
        end
        WRITE: begin
          if (mem_req_data_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BEAT) r_state <= IDLE;
          end
        end
        READ: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_resp_data <= ram[w_cur_idx];
            r_cnt       <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so preloaded/written lines survive reset.
  always_ff @(posedge clk) begin
    if (w_dat_fire) ram[w_cur_idx] <= mem_req_data_bits;
  end

`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
  logic r_err;
  assign mem_err = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_cmd_fire && ((mem_req_addr >> LINE_BITS) != '0)) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_backup_memory.sv
// Randomised bench for backup_memory against a line-array reference model.
module tb_backup_memory;

  localparam int AW = 26;
  localparam int TW = 5;
  localparam int DW = 128;
  localparam int NB = 4;
  localparam int DEPTH = 65536;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_data_valid;
  logic          mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
  logic          mem_err;
  logic          err_mdl;
`endif

  backup_memory dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data),
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    .mem_err            (mem_err),
`endif
    .mem_resp_tag       (mem_resp_tag)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] wdat [NB];
  int n_chk = 0;
  int n_pass = 0;
  logic [AW-1:0] last_addr = '0;

  function automatic int widx(input logic [AW-1:0] a, input int k);
    return int'((longint'(a) * NB + longint'(k)) % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_err();
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    check("mem_err", DW'(mem_err), DW'(err_mdl));
`endif
  endtask

  task automatic note_cmd(input logic [AW-1:0] a);
    last_addr = a;
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    if (longint'(a) >= longint'(DEPTH / NB)) err_mdl = 1'b1;
`endif
  endtask

  task automatic fill_random();
    for (int b = 0; b < NB; b++) wdat[b] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic do_write(input logic [AW-1:0] a, input logic [TW-1:0] t,
                          input int stall_at, input int stall_n);
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = a; mem_req_tag = t;
    @(negedge clk);
    check("wr_cmd_ready", DW'(mem_req_ready), DW'(1'b1));
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    note_cmd(a);
    for (int b = 0; b < NB; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          mem_req_data_valid = 1'b0;
          @(negedge clk);
          check("wr_stall_cmd_ready", DW'(mem_req_ready), '0);
          check("wr_stall_dat_ready", DW'(mem_req_data_ready), DW'(1'b1));
          @(posedge clk); #1;
        end
      end
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = wdat[b];
      @(negedge clk);
      check("wr_busy_cmd_ready", DW'(mem_req_ready), '0);
      check("wr_dat_ready", DW'(mem_req_data_ready), DW'(1'b1));
      @(posedge clk); #1;
      mdl[widx(a, b)] = wdat[b];
    end
    mem_req_data_valid = 1'b0;
    @(negedge clk);
    check("wr_done_ready", DW'(mem_req_ready), DW'(1'b1));
    check("wr_done_dat_ready", DW'(mem_req_data_ready), '0);
    check_err();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = a; mem_req_tag = t;
    @(negedge clk);
    check("rd_cmd_ready", DW'(mem_req_ready), DW'(1'b1));
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    note_cmd(a);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      check("rd_valid", DW'(mem_resp_valid), DW'(1'b1));
      check("rd_data", mem_resp_data, mdl[widx(a, k)]);
      check("rd_tag", DW'(mem_resp_tag), DW'(t));
      check("rd_busy_ready", DW'(mem_req_ready), '0);
    end
    @(negedge clk);
    check("rd_end_valid", DW'(mem_resp_valid), '0);
    check("rd_end_ready", DW'(mem_req_ready), DW'(1'b1));
    check("rd_hold_data", mem_resp_data, mdl[widx(a, NB - 1)]);
    check("rd_hold_tag", DW'(mem_resp_tag), DW'(t));
    check_err();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [TW-1:0] rt;
    reset = 1'b1;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_tag = '0;
    mem_req_data_valid = 1'b0; mem_req_data_bits = '0;
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    err_mdl = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      dut.ram[i] = '0;
      mdl[i] = '0;
    end

    @(negedge clk);
    check("rst_ready_low", DW'(mem_req_ready), '0);
    check("rst_resp_valid", DW'(mem_resp_valid), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", DW'(mem_req_ready), DW'(1'b1));
    check("post_rst_dat_ready", DW'(mem_req_data_ready), '0);
    check("post_rst_data", mem_resp_data, '0);
    check("post_rst_tag", DW'(mem_resp_tag), '0);
    check_err();
    @(posedge clk); #1;

    // Basic write then read of one line.
    wdat[0] = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a0;
    wdat[1] = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a1;
    wdat[2] = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a2;
    wdat[3] = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a3;
    do_write(AW'(26'h10), TW'(3), NB, 0);
    do_read(AW'(26'h10), TW'(7));

    // Write with a 3-cycle data gap between beats 1 and 2.
    fill_random();
    do_write(AW'(26'h20), TW'(5), 2, 3);
    do_read(AW'(26'h20), TW'(6));

    // Direct preload through the hierarchy.
    fill_random();
    for (int k = 0; k < NB; k++) begin
      dut.ram[k] = wdat[k];
      mdl[k] = wdat[k];
    end
    do_read(AW'(0), TW'(4));

    // Line DEPTH/NB aliases line 0.
    fill_random();
    do_write(AW'(DEPTH / NB), TW'(1), NB, 0);
    do_read(AW'(0), TW'(2));

    // Write data offered while idle must be ignored.
    mem_req_data_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      mem_req_data_bits = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("idle_dat_ready", DW'(mem_req_data_ready), '0);
      @(posedge clk); #1;
    end
    mem_req_data_valid = 1'b0;
    do_read(last_addr, TW'(8));

    // Reset after two response beats.
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = AW'(26'h10); mem_req_tag = TW'(9);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rrst_data", mem_resp_data, mdl[widx(AW'(26'h10), k)]);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rrst_valid", DW'(mem_resp_valid), '0);
    check("rrst_data_clr", mem_resp_data, '0);
    check("rrst_ready_low", DW'(mem_req_ready), '0);
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    err_mdl = 1'b0;
`endif
    @(negedge clk);
    check("rrst_ready", DW'(mem_req_ready), DW'(1'b1));
    check("rrst_valid2", DW'(mem_resp_valid), '0);
    check_err();
    @(posedge clk); #1;
    do_read(AW'(26'h10), TW'(9));

    // Random mix of reads and writes, some out of range.
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      rt = TW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        fill_random();
        do_write(ra, rt, int'($urandom_range(0, NB)), int'($urandom_range(0, 2)));
      end else begin
        do_read(ra, rt);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
